// File: rtl/calc_operand_fsm.sv
// Operand entry and add/subtract stage feeding the sign-magnitude display.
// Optional build macro CALC_SATURATE_EN clamps overflowed results to 8'h7F / 8'h80.
module calc_operand_fsm #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  input  logic       enter_n,
  input  logic       clear_n,
  input  logic       op_sub,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       overflow,
  output logic [1:0] phase
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    GET_A = 2'b00,
    GET_B = 2'b01,
    CALC  = 2'b10,
    SHOW  = 2'b11
  } state_t;

  // Button index 0 = enter, 1 = clear
  logic [7:0]    sw_s1, sw_s2;
  logic [1:0]    btn_s1, btn_s2;
  logic [1:0]    btn_lvl, btn_lvl_d;
  logic [CW-1:0] cnt [2];
  logic [CW-1:0] cnt_d [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '1;
      btn_s2 <= '1;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= {clear_n, enter_n};
      btn_s2 <= btn_s1;
    end
  end

  always_comb begin
    btn_lvl_d = btn_lvl;
    for (int unsigned i = 0; i < 2; i++) begin
      cnt_d[i] = cnt[i];
      if (btn_s2[i] == btn_lvl[i]) begin
        cnt_d[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        btn_lvl_d[i] = btn_s2[i];
        cnt_d[i]     = '0;
      end else begin
        cnt_d[i] = cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_lvl <= '1;
      for (int unsigned i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      btn_lvl <= btn_lvl_d;
      for (int unsigned i = 0; i < 2; i++) cnt[i] <= cnt_d[i];
    end
  end

  // Both buttons act on the newly accepted level so a simultaneous press resolves in one cycle.
  logic enter_pulse;
  logic clear_act;
  assign enter_pulse = btn_lvl[0] & ~btn_lvl_d[0];
  assign clear_act   = ~btn_lvl_d[1];

  state_t     state_q, state_d;
  logic [7:0] reg_a, reg_a_d;
  logic [7:0] reg_b, reg_b_d;
  logic       op_q, op_d;
  logic [7:0] result_q, result_d;
  logic       valid_q, valid_d;
  logic       ovf_q, ovf_d;
  logic [8:0] addend;
  logic [8:0] sum;
  logic       sum_ovf;
  logic [7:0] calc_res;

  always_comb begin
    addend  = {reg_b[7], reg_b} ^ {9{op_q}};
    sum     = {reg_a[7], reg_a} + addend + {8'd0, op_q};
    sum_ovf = sum[8] ^ sum[7];
`ifdef CALC_SATURATE_EN
    if (sum_ovf) calc_res = sum[8] ? 8'h80 : 8'h7F;
    else         calc_res = sum[7:0];
`else
    calc_res = sum[7:0];
`endif
  end

  always_comb begin
    state_d  = state_q;
    reg_a_d  = reg_a;
    reg_b_d  = reg_b;
    op_d     = op_q;
    result_d = result_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    if (clear_act) begin
      state_d  = GET_A;
      reg_a_d  = '0;
      reg_b_d  = '0;
      op_d     = 1'b0;
      ovf_d    = 1'b0;
      valid_d  = 1'b0;
      result_d = sw_s2;
    end else begin
      unique case (state_q)
        GET_A: begin
          result_d = sw_s2;
          if (enter_pulse) begin
            reg_a_d = sw_s2;
            state_d = GET_B;
          end
        end
        GET_B: begin
          result_d = sw_s2;
          if (enter_pulse) begin
            reg_b_d = sw_s2;
            op_d    = op_sub;
            state_d = CALC;
          end
        end
        CALC: begin
          result_d = calc_res;
          ovf_d    = sum_ovf;
          valid_d  = 1'b1;
          state_d  = SHOW;
        end
        SHOW: begin
          if (enter_pulse) begin
            state_d  = GET_A;
            valid_d  = 1'b0;
            ovf_d    = 1'b0;
            result_d = sw_s2;
          end
        end
        default: state_d = GET_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= GET_A;
      reg_a    <= '0;
      reg_b    <= '0;
      op_q     <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      reg_a    <= reg_a_d;
      reg_b    <= reg_b_d;
      op_q     <= op_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;
  assign overflow     = ovf_q;
  assign phase        = state_q;

endmodule

// File: tb/tb_calc_operand_fsm.sv
// Randomized and directed bench for calc_operand_fsm with an arithmetic reference model.
module tb_calc_operand_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw = 8'h00;
  logic       enter_n = 1'b1;
  logic       clear_n = 1'b1;
  logic       op_sub = 1'b0;
  logic [7:0] result;
  logic       result_valid;
  logic       overflow;
  logic [1:0] phase;

  int checks = 0;
  int errors = 0;

  calc_operand_fsm #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw(sw),
    .enter_n(enter_n),
    .clear_n(clear_n),
    .op_sub(op_sub),
    .result(result),
    .result_valid(result_valid),
    .overflow(overflow),
    .phase(phase)
  );

  always #5 clk = ~clk;

  // Returns {overflow, result} from signed integer arithmetic.
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic sub);
    int t;
    logic ov;
    logic [7:0] r;
    t  = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
    ov = (t > 127) || (t < -128);
    r  = t[7:0];
`ifdef CALC_SATURATE_EN
    if (ov) r = (t > 0) ? 8'h7F : 8'h80;
`endif
    return {ov, r};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hold);
    @(negedge clk);
    enter_n = 1'b0;
    cycles(hold);
    enter_n = 1'b1;
    cycles(8);
  endtask

  task automatic enter_operands(input logic [7:0] a, input logic [7:0] b, input logic sub);
    sw = a;
    press(8);
    sw = b;
    op_sub = sub;
    press(8);
  endtask

  task automatic test_reset;
    sw = 8'hA5;
    cycles(3);
    checks++;
    if ({phase, result, result_valid, overflow} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: phase=%b result=%h valid=%b ovf=%b, want 00/00/0/0",
               phase, result, result_valid, overflow);
    end
    rst_n = 1'b1;
    cycles(4);
    checks++;
    if (phase !== 2'b00 || result !== 8'hA5 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_echo: phase=%b result=%h valid=%b, want 00/a5/0", phase, result, result_valid);
    end
  endtask

  task automatic test_directed;
    logic [7:0] exp_r;
    sw = 8'd25;
    press(8);
    checks++;
    if (phase !== 2'b01) begin
      errors++;
      $display("FAIL accept_a: phase=%b want 01", phase);
    end
    sw = 8'd17;
    op_sub = 1'b0;
    press(8);
    checks++;
    if (phase !== 2'b11 || result !== 8'h2A || overflow !== 1'b0 || result_valid !== 1'b1) begin
      errors++;
      $display("FAIL add_25_17: phase=%b result=%h ovf=%b valid=%b want 11/2a/0/1",
               phase, result, overflow, result_valid);
    end
    press(8);
    checks++;
    if (phase !== 2'b00 || result_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL show_exit: phase=%b valid=%b ovf=%b want 00/0/0", phase, result_valid, overflow);
    end

`ifdef CALC_SATURATE_EN
    exp_r = 8'h7F;
`else
    exp_r = 8'h96;
`endif
    enter_operands(8'd100, 8'd50, 1'b0);
    checks++;
    if (result !== exp_r || overflow !== 1'b1 || result_valid !== 1'b1) begin
      errors++;
      $display("FAIL add_100_50: result=%h ovf=%b valid=%b want %h/1/1", result, overflow, result_valid, exp_r);
    end
    press(8);

`ifdef CALC_SATURATE_EN
    exp_r = 8'h80;
`else
    exp_r = 8'h7F;
`endif
    enter_operands(8'h80, 8'h01, 1'b1);
    checks++;
    if (result !== exp_r || overflow !== 1'b1) begin
      errors++;
      $display("FAIL sub_m128_1: result=%h ovf=%b want %h/1", result, overflow, exp_r);
    end
    press(8);

`ifdef CALC_SATURATE_EN
    exp_r = 8'h7F;
`else
    exp_r = 8'h80;
`endif
    enter_operands(8'h00, 8'h80, 1'b1);
    checks++;
    if (result !== exp_r || overflow !== 1'b1) begin
      errors++;
      $display("FAIL sub_0_m128: result=%h ovf=%b want %h/1", result, overflow, exp_r);
    end
    press(8);
  endtask

  task automatic test_latency;
    logic [1:0] hist [$];
    int n;
    bit seen;
    sw = 8'd7;
    press(8);
    sw = 8'd3;
    op_sub = 1'b1;
    @(negedge clk);
    enter_n = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      hist.push_back(phase);
      @(negedge clk);
      n++;
      if (result_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL latency_timeout: valid not seen in %0d cycles, want rise", n);
    end else if (hist.size() < 2 || hist[hist.size()-1] !== 2'b10 || hist[hist.size()-2] !== 2'b01) begin
      errors++;
      $display("FAIL calc_one_cycle: phases before valid %b,%b want 01,10",
               hist[hist.size()-2], hist[hist.size()-1]);
    end
    enter_n = 1'b1;
    cycles(8);
    checks++;
    if (result !== 8'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL sub_7_3: result=%h ovf=%b want 04/0", result, overflow);
    end
    press(8);
  endtask

  task automatic test_glitch;
    bit g [22] = '{0,0,0,1,1,0,1,0,0,1,0,0,0,1,1,1,1,1,1,1,1,1};
    sw = 8'h3C;
    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      enter_n = g[i];
      @(negedge clk);
    end
    enter_n = 1'b1;
    cycles(8);
    checks++;
    if (phase !== 2'b00) begin
      errors++;
      $display("FAIL glitch_reject: phase=%b want 00", phase);
    end
    press(30);
    checks++;
    if (phase !== 2'b01) begin
      errors++;
      $display("FAIL held_single: phase=%b want 01", phase);
    end
  endtask

  task automatic test_clear_enter;
    sw = 8'h5A;
    @(negedge clk);
    enter_n = 1'b0;
    clear_n = 1'b0;
    cycles(8);
    enter_n = 1'b1;
    clear_n = 1'b1;
    cycles(8);
    checks++;
    if (phase !== 2'b00 || result_valid !== 1'b0 || result !== 8'h5A) begin
      errors++;
      $display("FAIL clear_wins: phase=%b valid=%b result=%h want 00/0/5a", phase, result_valid, result);
    end
    sw = 8'hC3;
    cycles(4);
    checks++;
    if (result !== 8'hC3) begin
      errors++;
      $display("FAIL clear_echo: result=%h want c3", result);
    end
    enter_operands(8'd120, 8'd10, 1'b0);
    @(negedge clk);
    clear_n = 1'b0;
    cycles(8);
    clear_n = 1'b1;
    cycles(8);
    checks++;
    if (phase !== 2'b00 || result_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL clear_show: phase=%b valid=%b ovf=%b want 00/0/0", phase, result_valid, overflow);
    end
  endtask

  task automatic test_reset_mid_show;
    logic [8:0] e;
    enter_operands(8'd100, 8'd100, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({phase, result, result_valid, overflow} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: phase=%b result=%h valid=%b ovf=%b want 00/00/0/0",
               phase, result, result_valid, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    enter_operands(8'd25, 8'd17, 1'b0);
    e = model(8'd25, 8'd17, 1'b0);
    checks++;
    if (phase !== 2'b11 || result !== e[7:0] || overflow !== e[8]) begin
      errors++;
      $display("FAIL after_reset_calc: phase=%b result=%h ovf=%b want 11/%h/%b",
               phase, result, overflow, e[7:0], e[8]);
    end
    press(8);
  endtask

  task automatic test_random;
    logic [7:0] a, b, s;
    logic sub;
    logic [8:0] e;
    for (int i = 0; i < 25; i++) begin
      s = 8'($urandom_range(0, 255));
      sw = s;
      cycles(4);
      checks++;
      if (phase !== 2'b00 || result !== s || result_valid !== 1'b0) begin
        errors++;
        $display("FAIL rand_echo[%0d]: phase=%b result=%h valid=%b want 00/%h/0", i, phase, result, result_valid, s);
      end
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      sub = 1'($urandom_range(0, 1));
      enter_operands(a, b, sub);
      e = model(a, b, sub);
      checks++;
      if (phase !== 2'b11 || result !== e[7:0] || overflow !== e[8] || result_valid !== 1'b1) begin
        errors++;
        $display("FAIL rand_calc[%0d]: a=%h b=%h sub=%b got %h/%b/%b/%b want 11/%h/%b/1",
                 i, a, b, sub, phase, result, overflow, result_valid, e[7:0], e[8]);
      end
      press(8);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_latency;
    test_glitch;
    test_clear_enter;
    test_reset_mid_show;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
